// File: rtl/panda_clocks_pkg.sv
// Shared types and helpers for the panda_clocks_gen divider bank.
package panda_clocks_pkg;

    localparam int MAX_CLOCKS    = 16;
    localparam int MIN_PERIOD    = 2;
    localparam int MAX_DIV_WIDTH = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    typedef logic [MAX_DIV_WIDTH-1:0] div_word_t;

    // High time actually used: 0 means half period, and a width that would
    // cover the whole period is clipped so the output still toggles.
    function automatic div_word_t eff_width(input div_word_t period, input div_word_t width);
        div_word_t result;
        if (width == '0) begin
            result = period >> 1;
        end else if (width >= period) begin
            result = period - 1'b1;
        end else begin
            result = width;
        end
        return result;
    endfunction

endpackage

// File: rtl/panda_clocks_chan.sv
// One divider channel: shadowed period/width, counter and IDLE/RUN control.
module panda_clocks_chan
    import panda_clocks_pkg::*;
#(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 sync_i,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic [DIV_WIDTH-1:0] width,
    input  logic [DIV_WIDTH-1:0] phase,
    output logic                 clock_o,
    output logic                 active_o
);

    chan_state_t          state_reg, state_next;
    logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
    logic [DIV_WIDTH-1:0] p_reg, p_next;
    logic [DIV_WIDTH-1:0] w_reg, w_next;
    logic                 clock_reg, clock_next;
    logic                 active_reg, active_next;

    logic                 live_ok;
    logic [DIV_WIDTH-1:0] start_cnt;
    logic [DIV_WIDTH-1:0] we_live;
    logic [DIV_WIDTH-1:0] we_cur;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic                 wrap;

    always_comb begin
        live_ok   = (period >= DIV_WIDTH'(MIN_PERIOD));
        start_cnt = ((phase != '0) && (phase < period)) ? (period - phase) : '0;
        we_live   = DIV_WIDTH'(eff_width(div_word_t'(period), div_word_t'(width)));
        we_cur    = DIV_WIDTH'(eff_width(div_word_t'(p_reg), div_word_t'(w_reg)));
        cnt_inc   = cnt_reg + 1'b1;
        wrap      = (cnt_reg == (p_reg - 1'b1));
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        p_next      = p_reg;
        w_next      = w_reg;
        clock_next  = clock_reg;
        active_next = active_reg;

        // Start (enable rise or sync) and stop share one action each.
        if ((state_reg == IDLE && enable_i && live_ok) ||
            (state_reg == RUN && enable_i && sync_i && live_ok)) begin
            state_next  = RUN;
            p_next      = period;
            w_next      = width;
            cnt_next    = start_cnt;
            clock_next  = (start_cnt < we_live);
            active_next = 1'b1;
        end else if (state_reg == RUN &&
                     (!enable_i || ((sync_i || wrap) && !live_ok))) begin
            state_next  = IDLE;
            cnt_next    = '0;
            clock_next  = 1'b0;
            active_next = 1'b0;
        end else if (state_reg == RUN && wrap) begin
            cnt_next   = '0;
            p_next     = period;
            w_next     = width;
            clock_next = (we_live != '0);
        end else if (state_reg == RUN) begin
            cnt_next   = cnt_inc;
            clock_next = (cnt_inc < we_cur);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            p_reg      <= '0;
            w_reg      <= '0;
            clock_reg  <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            p_reg      <= p_next;
            w_reg      <= w_next;
            clock_reg  <= clock_next;
            active_reg <= active_next;
        end
    end

    assign clock_o  = clock_reg;
    assign active_o = active_reg;

endmodule

// File: rtl/panda_clocks_gen.sv
// Bank of NUM_CLOCKS programmable clock dividers with shared sync strobe.
// Define CLOCKS_PHASE_EN to add the per-channel PHASE start-delay input.
module panda_clocks_gen
    import panda_clocks_pkg::*;
#(
    parameter int NUM_CLOCKS = 4,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_CLOCKS-1:0]           enable_i,
    input  logic                            sync_i,
    input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] PERIOD,
    input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] WIDTH,
`ifdef CLOCKS_PHASE_EN
    input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] PHASE,
`endif
    output logic [NUM_CLOCKS-1:0]           clock_o,
    output logic [NUM_CLOCKS-1:0]           active_o
);

    logic [NUM_CLOCKS*DIV_WIDTH-1:0] phase_vec;

`ifdef CLOCKS_PHASE_EN
    assign phase_vec = PHASE;
`else
    assign phase_vec = '0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
            panda_clocks_chan #(
                .DIV_WIDTH (DIV_WIDTH)
            ) u_chan (
                .clk_i    (clk_i),
                .reset_i  (reset_i),
                .enable_i (enable_i[gi]),
                .sync_i   (sync_i),
                .period   (PERIOD[gi*DIV_WIDTH +: DIV_WIDTH]),
                .width    (WIDTH[gi*DIV_WIDTH +: DIV_WIDTH]),
                .phase    (phase_vec[gi*DIV_WIDTH +: DIV_WIDTH]),
                .clock_o  (clock_o[gi]),
                .active_o (active_o[gi])
            );
        end
    endgenerate

endmodule
